sd_clk_gen: RTL and testbench

Programmable SD card clock generator for the host controller. It consumes the half-period count and load strobe produced by the clock-divider count generator. From the 50 MHz system clock it produces a 50%-duty, glitch-free sd_clk, plus one-cycle edge strobes for the command/data shifters. Divisor changes and clock stop/start happen only at safe phase boundaries, so sd_clk never has a runt pulse.

---
 rtl/sd_clk_gen.sv | 127 ++++++++++++
 tb/tb_sd_clk_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_gen.sv
// SD card clock generator: 50%-duty sd_clk from the system clock with edge strobes.
// Divisor changes and start/stop only take effect at phase boundaries, so sd_clk never runts.
module sd_clk_gen #(
   parameter int unsigned     CW       = 16,
   parameter logic [CW-1:0]   INIT_DIV = 16'd63
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] count,
   input  logic          load,
   input  logic          en,
   output logic          sd_clk,
   output logic          rise_stb,
   output logic          fall_stb,
   output logic          stopped,
   output logic [CW-1:0] cur_div
);

   typedef enum logic [1:0] {
      ST_STOP,
      ST_LOW,
      ST_HIGH
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cur_div_q;
   logic [CW-1:0] pend_q;
   logic          pend_vld_q;
   logic          sd_clk_q;
   logic          rise_q;
   logic          fall_q;
   logic          stopped_q;

   logic [CW-1:0] eff_count;
   logic [CW-1:0] cur_div_d;
   logic          last_cnt;

   assign eff_count = (count == '0) ? CW'(1) : count;
   assign last_cnt  = (cnt_q == cur_div_q - CW'(1));

   // At an apply point a same-cycle load wins over the older pending value.
   always_comb begin
      cur_div_d = cur_div_q;
      if (load) begin
         cur_div_d = eff_count;
      end else if (pend_vld_q) begin
         cur_div_d = pend_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_STOP;
         cnt_q      <= '0;
         cur_div_q  <= INIT_DIV;
         pend_q     <= INIT_DIV;
         pend_vld_q <= 1'b0;
         sd_clk_q   <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         stopped_q  <= 1'b1;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (load) begin
            pend_q     <= eff_count;
            pend_vld_q <= 1'b1;
         end
         case (state_q)
            ST_STOP: begin
               sd_clk_q   <= 1'b0;
               cnt_q      <= '0;
               cur_div_q  <= cur_div_d;
               pend_vld_q <= 1'b0;
               if (en) begin
                  state_q   <= ST_LOW;
                  stopped_q <= 1'b0;
               end else begin
                  stopped_q <= 1'b1;
               end
            end
            ST_LOW: begin
               if (last_cnt) begin
                  cnt_q <= '0;
                  if (en) begin
                     state_q  <= ST_HIGH;
                     sd_clk_q <= 1'b1;
                     rise_q   <= 1'b1;
                  end else begin
                     state_q   <= ST_STOP;
                     stopped_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_HIGH: begin
               // en is not sampled here: a started high phase always completes.
               if (last_cnt) begin
                  state_q    <= ST_LOW;
                  sd_clk_q   <= 1'b0;
                  fall_q     <= 1'b1;
                  cnt_q      <= '0;
                  cur_div_q  <= cur_div_d;
                  pend_vld_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q   <= ST_STOP;
               sd_clk_q  <= 1'b0;
               cnt_q     <= '0;
               stopped_q <= 1'b1;
            end
         endcase
      end
   end

   assign sd_clk   = sd_clk_q;
   assign rise_stb = rise_q;
   assign fall_stb = fall_q;
   assign stopped  = stopped_q;
   assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: vector table plus hand-built corner sequences, checked through
// an expectation queue filled when stimulus is driven and drained when outputs are sampled.
module tb_sd_clk_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] count;
   logic        load;
   logic        en;
   logic        sd_clk;
   logic        rise_stb;
   logic        fall_stb;
   logic        stopped;
   logic [15:0] cur_div;

   sd_clk_gen #(.CW(16), .INIT_DIV(16'd63)) dut (
      .clk      (clk),
      .reset    (reset),
      .count    (count),
      .load     (load),
      .en       (en),
      .sd_clk   (sd_clk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb),
      .stopped  (stopped),
      .cur_div  (cur_div)
   );

   always #5 clk = ~clk;

   // adv: number of clk edges to run after applying inputs (load held for the first only);
   // adv == 0 samples 1 time unit later without a clock edge (asynchronous reset check).
   typedef struct {
      string       tag;
      logic        rst_n;
      logic        en;
      logic        ld;
      logic [15:0] cnt;
      int unsigned adv;
      logic        e_clk;
      logic        e_rise;
      logic        e_fall;
      logic        e_stop;
      logic [15:0] e_div;
   } vec_t;

   typedef struct {
      string       tag;
      logic        e_clk;
      logic        e_rise;
      logic        e_fall;
      logic        e_stop;
      logic [15:0] e_div;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   function automatic vec_t mk(input string tag, input logic r, input logic e, input logic l,
                               input logic [15:0] c, input int unsigned adv, input logic xc,
                               input logic xr, input logic xf, input logic xs,
                               input logic [15:0] xd);
      vec_t v;
      v.tag = tag; v.rst_n = r; v.en = e; v.ld = l; v.cnt = c; v.adv = adv;
      v.e_clk = xc; v.e_rise = xr; v.e_fall = xf; v.e_stop = xs; v.e_div = xd;
      return v;
   endfunction

   task automatic check_pop();
      exp_t x;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_empty: no expectation queued");
      end else begin
         x = sb.pop_front();
         n_cmp++;
         if (sd_clk !== x.e_clk || rise_stb !== x.e_rise || fall_stb !== x.e_fall ||
             stopped !== x.e_stop || cur_div !== x.e_div) begin
            n_err++;
            $display("FAIL %s: got clk=%0b rise=%0b fall=%0b stopped=%0b div=%0d, want clk=%0b rise=%0b fall=%0b stopped=%0b div=%0d",
                     x.tag, sd_clk, rise_stb, fall_stb, stopped, cur_div,
                     x.e_clk, x.e_rise, x.e_fall, x.e_stop, x.e_div);
         end
      end
   endtask

   task automatic step(input vec_t v);
      exp_t x;
      reset = v.rst_n;
      en    = v.en;
      load  = v.ld;
      count = v.cnt;
      x.tag = v.tag; x.e_clk = v.e_clk; x.e_rise = v.e_rise; x.e_fall = v.e_fall;
      x.e_stop = v.e_stop; x.e_div = v.e_div;
      sb.push_back(x);
      if (v.adv == 0) begin
         #1;
      end else begin
         @(negedge clk);
         load = 1'b0;
         for (int unsigned i = 1; i < v.adv; i++) @(negedge clk);
      end
      check_pop();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      en    = 1'b0;
      load  = 1'b0;
      count = '0;

      //              tag              rst en ld cnt adv  clk ri fa st div
      tbl.push_back(mk("reset",        0, 0, 0, 0,  1,   0, 0, 0, 1, 63));
      tbl.push_back(mk("idle20",       1, 0, 0, 0,  20,  0, 0, 0, 1, 63));
      tbl.push_back(mk("pre_rise",     1, 1, 0, 0,  63,  0, 0, 0, 0, 63));
      tbl.push_back(mk("first_rise",   1, 1, 0, 0,  1,   1, 1, 0, 0, 63));
      tbl.push_back(mk("rise_single",  1, 1, 0, 0,  1,   1, 0, 0, 0, 63));
      tbl.push_back(mk("high_end",     1, 1, 0, 0,  61,  1, 0, 0, 0, 63));
      tbl.push_back(mk("fall63",       1, 1, 0, 0,  1,   0, 0, 1, 0, 63));
      tbl.push_back(mk("rise_p126",    1, 1, 0, 0,  63,  1, 1, 0, 0, 63));
      tbl.push_back(mk("fall_en_off",  1, 0, 0, 0,  63,  0, 0, 1, 0, 63));
      tbl.push_back(mk("low_tail",     1, 0, 0, 0,  62,  0, 0, 0, 0, 63));
      tbl.push_back(mk("stopped",      1, 0, 0, 0,  1,   0, 0, 0, 1, 63));
      tbl.push_back(mk("load1_stop",   1, 0, 1, 1,  2,   0, 0, 0, 1, 1));
      tbl.push_back(mk("d1_start",     1, 1, 0, 0,  1,   0, 0, 0, 0, 1));
      tbl.push_back(mk("d1_rise_a",    1, 1, 0, 0,  1,   1, 1, 0, 0, 1));
      tbl.push_back(mk("d1_fall_a",    1, 1, 0, 0,  1,   0, 0, 1, 0, 1));
      tbl.push_back(mk("d1_rise_b",    1, 1, 0, 0,  1,   1, 1, 0, 0, 1));
      tbl.push_back(mk("d1_fall_b",    1, 0, 0, 0,  1,   0, 0, 1, 0, 1));
      tbl.push_back(mk("d1_stop",      1, 0, 0, 0,  1,   0, 0, 0, 1, 1));
      tbl.push_back(mk("load5_stop",   1, 0, 1, 5,  1,   0, 0, 0, 1, 5));
      tbl.push_back(mk("load0_eff1",   1, 0, 1, 0,  1,   0, 0, 0, 1, 1));
      tbl.push_back(mk("d0_start",     1, 1, 0, 0,  1,   0, 0, 0, 0, 1));
      tbl.push_back(mk("d0_rise",      1, 1, 0, 0,  1,   1, 1, 0, 0, 1));
      tbl.push_back(mk("d0_fall",      1, 0, 0, 0,  1,   0, 0, 1, 0, 1));
      tbl.push_back(mk("d0_stop",      1, 0, 0, 0,  1,   0, 0, 0, 1, 1));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Load during a 63-cycle high phase: phase still completes, new divisor at the fall.
      step(mk("mid_rise63",    1, 1, 1, 63, 64, 1, 1, 0, 0, 63));
      step(mk("mid_high10",    1, 1, 0, 0,  10, 1, 0, 0, 0, 63));
      step(mk("mid_load2",     1, 1, 1, 2,  1,  1, 0, 0, 0, 63));
      step(mk("mid_not_yet",   1, 1, 0, 0,  51, 1, 0, 0, 0, 63));
      step(mk("mid_applied",   1, 1, 0, 0,  1,  0, 0, 1, 0, 2));
      step(mk("d2_rise",       1, 1, 0, 0,  2,  1, 1, 0, 0, 2));
      step(mk("d2_fall",       1, 1, 0, 0,  2,  0, 0, 1, 0, 2));

      // Switch to div 4, then drop en one cycle into a high phase.
      step(mk("d4_load",       1, 1, 1, 4,  1,  0, 0, 0, 0, 2));
      step(mk("d4_pre_rise",   1, 1, 0, 0,  1,  1, 1, 0, 0, 2));
      step(mk("d4_applied",    1, 1, 0, 0,  2,  0, 0, 1, 0, 4));
      step(mk("d4_rise",       1, 1, 0, 0,  4,  1, 1, 0, 0, 4));
      step(mk("d4_high1",      1, 1, 0, 0,  1,  1, 0, 0, 0, 4));
      step(mk("en_off_high",   1, 0, 0, 0,  2,  1, 0, 0, 0, 4));
      step(mk("en_off_fall",   1, 0, 0, 0,  1,  0, 0, 1, 0, 4));
      step(mk("en_off_low",    1, 0, 0, 0,  3,  0, 0, 0, 0, 4));
      step(mk("en_off_stop",   1, 0, 0, 0,  1,  0, 0, 0, 1, 4));
      step(mk("stop_hold",     1, 0, 0, 0,  2,  0, 0, 0, 1, 4));
      step(mk("restart_low",   1, 1, 0, 0,  4,  0, 0, 0, 0, 4));
      step(mk("restart_rise",  1, 1, 0, 0,  1,  1, 1, 0, 0, 4));

      // Reset in the middle of a div-8 high phase with a load still pending.
      step(mk("d8_load",       1, 1, 1, 8,  1,  1, 0, 0, 0, 4));
      step(mk("d8_applied",    1, 1, 0, 0,  3,  0, 0, 1, 0, 8));
      step(mk("d8_rise",       1, 1, 0, 0,  8,  1, 1, 0, 0, 8));
      step(mk("d8_high3",      1, 1, 0, 0,  3,  1, 0, 0, 0, 8));
      step(mk("pend20",        1, 1, 1, 20, 1,  1, 0, 0, 0, 8));
      step(mk("async_reset",   0, 1, 0, 0,  0,  0, 0, 0, 1, 63));
      step(mk("reset_held",    0, 0, 0, 0,  2,  0, 0, 0, 1, 63));
      step(mk("pend_discard",  1, 0, 0, 0,  3,  0, 0, 0, 1, 63));
      step(mk("post_rst_low",  1, 1, 0, 0,  63, 0, 0, 0, 0, 63));
      step(mk("post_rst_rise", 1, 1, 0, 0,  1,  1, 1, 0, 0, 63));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
